// File: rtl/addr_slot_alloc.sv
// Tracked-address table for the address comparator: allocates slots 1..NUM_SLOTS,
// stores addresses, refreshes age on comparator hits and frees slots on release or timeout.
module addr_slot_alloc #(
  parameter int          NUM_SLOTS = 14,
  parameter int          ADDR_W    = 19,
  parameter int          SLOT_W    = 4,
  parameter int          AGE_W     = 16,
  parameter int unsigned AGE_MAX   = 32'h0000_FFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [ADDR_W-1:0]             alloc_addr,
  input  logic                          release_req,
  input  logic [SLOT_W-1:0]             release_slot,
  input  logic                          hit_valid,
  input  logic [SLOT_W-1:0]             hit_slot,
  output logic                          alloc_done,
  output logic                          alloc_ok,
  output logic                          alloc_dup,
  output logic [SLOT_W-1:0]             alloc_slot,
  output logic [NUM_SLOTS*ADDR_W-1:0]   slot_addr,
  output logic [NUM_SLOTS-1:0]          slot_ena,
  output logic [SLOT_W-1:0]             free_count,
  output logic                          expire_valid,
  output logic [SLOT_W-1:0]             expire_slot
);

  // Handshake: alloc_req is a single-cycle request sampled every cycle; alloc_done is
  // its registered reply one cycle later, with alloc_ok/alloc_dup/alloc_slot valid only
  // while alloc_done is high. There is no back-pressure.

  localparam bit                AGING    = (AGE_MAX != 0);
  localparam logic [AGE_W-1:0]  AGE_LAST = AGE_W'(AGE_MAX - 1);

  typedef enum logic {SLOT_FREE = 1'b0, SLOT_VALID = 1'b1} slot_state_t;

  slot_state_t       state_q [NUM_SLOTS];
  logic [ADDR_W-1:0] addr_q  [NUM_SLOTS];
  logic [AGE_W-1:0]  age_q   [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] valid_vec;
  logic [NUM_SLOTS-1:0] grant_vec;
  logic [NUM_SLOTS-1:0] dup_vec;
  logic [NUM_SLOTS-1:0] rel_vec;
  logic [NUM_SLOTS-1:0] refresh_vec;
  logic [NUM_SLOTS-1:0] exp_vec;
  logic [NUM_SLOTS-1:0] ena_next;
  logic [SLOT_W-1:0]    match_slot;
  logic [SLOT_W-1:0]    free_slot;
  logic [SLOT_W-1:0]    exp_slot_next;
  logic [SLOT_W-1:0]    busy_cnt;

  always_comb begin
    valid_vec     = '0;
    grant_vec     = '0;
    dup_vec       = '0;
    rel_vec       = '0;
    refresh_vec   = '0;
    exp_vec       = '0;
    ena_next      = '0;
    match_slot    = '0;
    free_slot     = '0;
    exp_slot_next = '0;
    busy_cnt      = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      valid_vec[i] = (state_q[i] == SLOT_VALID);
    end
    // Scan downwards so the lowest-numbered candidate is the one left standing.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_vec[i] && (addr_q[i] == alloc_addr)) match_slot = SLOT_W'(i + 1);
      if (!valid_vec[i]) free_slot = SLOT_W'(i + 1);
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dup_vec[i]     = alloc_req && (match_slot == SLOT_W'(i + 1));
      grant_vec[i]   = alloc_req && (match_slot == '0) && (free_slot == SLOT_W'(i + 1));
      rel_vec[i]     = release_req && (release_slot == SLOT_W'(i + 1)) && valid_vec[i];
      refresh_vec[i] = valid_vec[i] &&
                       ((hit_valid && (hit_slot == SLOT_W'(i + 1))) || dup_vec[i]);
      exp_vec[i]     = AGING && valid_vec[i] && (age_q[i] == AGE_LAST) && !refresh_vec[i];
      ena_next[i]    = grant_vec[i] || (valid_vec[i] && !rel_vec[i] && !exp_vec[i]);
      busy_cnt       = busy_cnt + SLOT_W'(ena_next[i]);
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (exp_vec[i]) exp_slot_next = SLOT_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= SLOT_FREE;
        addr_q[i]  <= '0;
        age_q[i]   <= '0;
      end
      alloc_done   <= 1'b0;
      alloc_ok     <= 1'b0;
      alloc_dup    <= 1'b0;
      alloc_slot   <= '0;
      free_count   <= SLOT_W'(NUM_SLOTS);
      expire_valid <= 1'b0;
      expire_slot  <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= ena_next[i] ? SLOT_VALID : SLOT_FREE;
        if (grant_vec[i]) addr_q[i] <= alloc_addr;
        if (grant_vec[i] || refresh_vec[i] || !ena_next[i]) begin
          age_q[i] <= '0;
        end else if (AGING && (age_q[i] != '1)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
      alloc_done   <= alloc_req;
      alloc_ok     <= alloc_req && ((match_slot != '0) || (free_slot != '0));
      alloc_dup    <= alloc_req && (match_slot != '0);
      alloc_slot   <= !alloc_req ? '0 : ((match_slot != '0) ? match_slot : free_slot);
      free_count   <= SLOT_W'(NUM_SLOTS) - busy_cnt;
      expire_valid <= |exp_vec;
      expire_slot  <= exp_slot_next;
    end
  end

  always_comb begin
    slot_addr = '0;
    slot_ena  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
      slot_ena[i]                   = (state_q[i] == SLOT_VALID);
    end
  end

endmodule
